instr_mem_param: RTL and testbench

INSTR_MEM_PARAM -- requirements
Module: instr_mem_param

---
 rtl/instr_mem_param_pkg.sv | 17 +
 rtl/imem_ram.sv | 49 ++++
 rtl/instr_mem_param.sv | 156 +++++++++++++++
 tb/tb_instr_mem_param.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_param_pkg.sv
// Shared types and constants for the instruction memory block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package instr_mem_param_pkg;

  // Controller states. CLEAR wipes the array, IDLE serves fetches,
  // LOAD accepts program writes.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Word returned for cleared or out-of-range locations unless overridden.
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Latency: 1 cycle from re to rdata; rdata holds its value while re is low.
// Backpressure: none, one access per cycle on the shared address.
//
// Ports:
//   clock        rising-edge clock
//   we / re      write / read enable (caller never asserts both)
//   addr         word address, caller keeps it below DEPTH
//   wdata        write data
//   rdata        registered read data
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr;

  // Upper address bits are always zero for in-range accesses.
  assign idx         = addr[IDX_W-1:0];
  assign unused_addr = ^addr;

  // Read data only moves on a read, so a result stays put across idle
  // cycles and across writes.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[idx] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_param.sv
// Instruction memory with power-on clear, program-load mode and fetch port.
// Latency: fetch result valid 1 cycle after acceptance; held until next fetch.
// Backpressure: fetch_ready low while clearing, loading or load_mode requested.
//
// Ports:
//   clock, reset                          clock and synchronous active-high reset
//   fetch_req/addr, fetch_ready           fetch request handshake
//   fetch_valid/data/err                  fetch result (err: address >= DEPTH)
//   load_mode, load_we/addr/data          program-load control and write port
//   busy                                  high while clearing or loading
module instr_mem_param
  import instr_mem_param_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_mode,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic              fetch_in_range;
  logic              load_in_range;
  logic              fetch_acc;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_L;
  assign load_in_range  = {1'b0, load_addr}  < DEPTH_L;

  // State register. Reset always restarts the clear sweep from address 0,
  // which also discards any partially loaded program.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Next-state logic. CLEAR spends exactly DEPTH cycles, one word each.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (load_mode) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!load_mode) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Outputs and RAM control.
  always_comb begin
    fetch_ready   = (state_q == ST_IDLE) && !load_mode;
    busy          = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
    fetch_acc     = fetch_ready && fetch_req;

    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = fetch_addr;
    ram_wdata     = load_data;
    fetch_valid_d = fetch_valid_q;
    fetch_err_d   = fetch_err_q;

    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = NOP_WORD;
      end
      ST_IDLE: begin
        if (load_mode) begin
          // load_mode wins over a simultaneous fetch; stale result is retired.
          fetch_valid_d = 1'b0;
          fetch_err_d   = 1'b0;
        end else if (fetch_acc) begin
          fetch_valid_d = 1'b1;
          fetch_err_d   = !fetch_in_range;
          // Out-of-range fetches skip the RAM; the data mux supplies NOP_WORD.
          ram_re        = fetch_in_range;
        end
      end
      ST_LOAD: begin
        ram_addr = load_addr;
        ram_we   = load_we && load_in_range;
      end
      default: ;
    endcase

    if (reset) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_data  = (fetch_valid_q && !fetch_err_q) ? ram_rdata : NOP_WORD;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_instr_mem_param.sv
// Bench for instr_mem_param: a default instance (DEPTH 256, NOP 0) and a
// DEPTH 64 instance with a non-zero NOP word share one stimulus stream.
// Expected results come from a word-level memory model kept here.
module tb_instr_mem_param;

  localparam logic [31:0] A_NOP = 32'h0000_0000;
  localparam logic [31:0] B_NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        load_mode;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        a_rdy, a_vld, a_err, a_busy;
  logic [31:0] a_dat;
  logic        b_rdy, b_vld, b_err, b_busy;
  logic [31:0] b_dat;

  int n_vec = 0;
  int n_err = 0;

  // Model: what was loaded; unwritten locations read as the instance's NOP.
  logic [31:0] mdl_mem [256];
  bit          mdl_wr  [256];

  int          fq[$];
  int          lq_addr[$];
  logic [31:0] lq_data[$];

  instr_mem_param dut_a (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (a_rdy),
    .fetch_valid (a_vld),
    .fetch_data  (a_dat),
    .fetch_err   (a_err),
    .load_mode   (load_mode),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (a_busy)
  );

  instr_mem_param #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .DEPTH    (64),
    .NOP_WORD (B_NOP)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (b_rdy),
    .fetch_valid (b_vld),
    .fetch_data  (b_dat),
    .fetch_err   (b_err),
    .load_mode   (load_mode),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (b_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mdl_wr[i] = 1'b0;
  endtask

  // {err, data} a fetch of addr should return from a memory of given depth.
  function automatic logic [32:0] exp_fetch(int addr, int depth, logic [31:0] nop);
    if (addr >= depth) return {1'b1, nop};
    if (!mdl_wr[addr]) return {1'b0, nop};
    return {1'b0, mdl_mem[addr]};
  endfunction

  // Called right after a reset edge with reset already released: counts
  // busy cycles of each instance and checks it ends ready.
  task automatic wait_clear(input string tag);
    int ca = 0;
    int cb = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      tick();
    end
    n_vec++;
    if (ca !== 256) begin
      n_err++;
      $display("FAIL %s busy_cycles_a: got %0d want 256", tag, ca);
    end
    n_vec++;
    if (cb !== 64) begin
      n_err++;
      $display("FAIL %s busy_cycles_b: got %0d want 64", tag, cb);
    end
    n_vec++;
    if ({a_rdy, a_busy, b_rdy, b_busy} !== 4'b1010) begin
      n_err++;
      $display("FAIL %s ready_after_clear: got rdy/busy a=%b%b b=%b%b want 10 10",
               tag, a_rdy, a_busy, b_rdy, b_busy);
    end
  endtask

  // Back-to-back fetches of fq; inactive load_we noise must be ignored.
  task automatic run_fetches(input string tag);
    logic [32:0] ea, eb;
    for (int i = 0; i < fq.size(); i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(fq[i]);
      load_we    = 1'($urandom);
      load_addr  = 8'($urandom);
      load_data  = $urandom;
      #1;
      n_vec++;
      if ({a_rdy, b_rdy} !== 2'b11) begin
        n_err++;
        $display("FAIL %s fetch_ready: got a=%b b=%b want 1 1", tag, a_rdy, b_rdy);
      end
      tick();
      ea = exp_fetch(fq[i], 256, A_NOP);
      eb = exp_fetch(fq[i], 64, B_NOP);
      n_vec++;
      if ({a_vld, a_err, a_dat} !== {1'b1, ea}) begin
        n_err++;
        $display("FAIL %s fetch_a addr %0d: got vld=%b err=%b dat=%h want 1 %b %h",
                 tag, fq[i], a_vld, a_err, a_dat, ea[32], ea[31:0]);
      end
      n_vec++;
      if ({b_vld, b_err, b_dat} !== {1'b1, eb}) begin
        n_err++;
        $display("FAIL %s fetch_b addr %0d: got vld=%b err=%b dat=%h want 1 %b %h",
                 tag, fq[i], b_vld, b_err, b_dat, eb[32], eb[31:0]);
      end
    end
    fetch_req = 1'b0;
    load_we   = 1'b0;
  endtask

  // Load session writing lq; stops early (still in LOAD) at abort_after.
  task automatic run_load(input string tag, input int abort_after);
    load_mode = 1'b1;
    tick();
    n_vec++;
    if ({a_vld, a_busy, b_vld, b_busy} !== 4'b0101) begin
      n_err++;
      $display("FAIL %s enter_load: got vld/busy a=%b%b b=%b%b want 01 01",
               tag, a_vld, a_busy, b_vld, b_busy);
    end
    for (int i = 0; i < lq_addr.size(); i++) begin
      if (i == abort_after) return;
      load_we   = 1'b1;
      load_addr = 8'(lq_addr[i]);
      load_data = lq_data[i];
      tick();
      mdl_mem[lq_addr[i]] = lq_data[i];
      mdl_wr[lq_addr[i]]  = 1'b1;
    end
    load_we   = 1'b0;
    load_mode = 1'b0;
    tick();
    n_vec++;
    if ({a_busy, b_busy, a_rdy, b_rdy} !== 4'b0011) begin
      n_err++;
      $display("FAIL %s exit_load: got busy a=%b b=%b rdy a=%b b=%b want 0 0 1 1",
               tag, a_busy, b_busy, a_rdy, b_rdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_mode = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    tick();
    tick();
    n_vec++;
    if ({a_busy, a_rdy, a_vld, a_err, a_dat} !== {4'b1000, A_NOP}) begin
      n_err++;
      $display("FAIL reset_a: got busy=%b rdy=%b vld=%b err=%b dat=%h", a_busy, a_rdy, a_vld, a_err, a_dat);
    end
    n_vec++;
    if ({b_busy, b_rdy, b_vld, b_err, b_dat} !== {4'b1000, B_NOP}) begin
      n_err++;
      $display("FAIL reset_b: got busy=%b rdy=%b vld=%b err=%b dat=%h", b_busy, b_rdy, b_vld, b_err, b_dat);
    end
    reset = 1'b0;
    model_clear();
    wait_clear("reset");
    fq = '{100, 0, 255, 63};
    run_fetches("after_clear");
  endtask

  task automatic test_load();
    lq_addr = '{2, 7};
    lq_data = '{32'h7104_1000, 32'h5104_FC00};
    run_load("load", -1);
    fq = '{2, 7};
    run_fetches("load_readback");
  endtask

  task automatic test_err_boundary();
    fq = '{64, 3, 63, 255, 7};
    run_fetches("boundary");
  endtask

  task automatic test_priority();
    fq = '{2};
    run_fetches("prio_pre");
    load_mode  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'd7;
    #1;
    n_vec++;
    if ({a_rdy, b_rdy} !== 2'b00) begin
      n_err++;
      $display("FAIL prio_ready: got a=%b b=%b want 0 0", a_rdy, b_rdy);
    end
    tick();
    n_vec++;
    if ({a_vld, a_busy, b_vld, b_busy} !== 4'b0101) begin
      n_err++;
      $display("FAIL prio_result: got vld/busy a=%b%b b=%b%b want 01 01", a_vld, a_busy, b_vld, b_busy);
    end
    fetch_req = 1'b0;
    load_mode = 1'b0;
    tick();
    n_vec++;
    if ({a_vld, a_busy, b_vld, b_busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL prio_exit: got vld/busy a=%b%b b=%b%b want 00 00", a_vld, a_busy, b_vld, b_busy);
    end
  endtask

  task automatic test_hold();
    logic [32:0] ea, eb;
    logic [7:0]  noise_addr [10];
    fq = '{7};
    run_fetches("hold_fetch");
    ea = exp_fetch(7, 256, A_NOP);
    eb = exp_fetch(7, 64, B_NOP);
    for (int i = 0; i < 10; i++) begin
      load_we       = 1'b1;
      noise_addr[i] = 8'($urandom_range(0, 15));
      load_addr     = noise_addr[i];
      load_data     = $urandom;
      tick();
      n_vec++;
      if ({a_vld, a_err, a_dat, b_vld, b_err, b_dat} !== {1'b1, ea, 1'b1, eb}) begin
        n_err++;
        $display("FAIL hold cycle %0d: got a=%b%b%h b=%b%b%h want a=1%b%h b=1%b%h",
                 i, a_vld, a_err, a_dat, b_vld, b_err, b_dat, ea[32], ea[31:0], eb[32], eb[31:0]);
      end
    end
    load_we = 1'b0;
    fq = '{};
    for (int i = 0; i < 10; i++) fq.push_back(int'(noise_addr[i]));
    run_fetches("idle_we_ignored");
  endtask

  task automatic test_reset_mid_load();
    lq_addr = '{20, 21, 22, 23, 24};
    lq_data = '{};
    for (int i = 0; i < 5; i++) lq_data.push_back($urandom);
    run_load("partial", 3);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    load_mode = 1'b0;
    load_we   = 1'b0;
    model_clear();
    // Second reset lands mid-clear and must restart the sweep.
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear("reclear");
    fq = '{20, 21, 22, 23, 24, 2, 7};
    run_fetches("after_abort");
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          n = $urandom_range(1, 4);
          lq_addr = '{};
          lq_data = '{};
          for (int k = 0; k < n; k++) begin
            lq_addr.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15));
            lq_data.push_back($urandom);
          end
          run_load("rnd_load", -1);
        end
        1: begin
          n = $urandom_range(1, 4);
          fq = '{};
          for (int k = 0; k < n; k++)
            fq.push_back(($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15));
          run_fetches("rnd_fetch");
        end
        default: begin
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) begin
            load_we   = 1'($urandom);
            load_addr = 8'($urandom_range(0, 15));
            load_data = $urandom;
            tick();
          end
          load_we = 1'b0;
        end
      endcase
    end
    fq = '{};
    for (int k = 0; k < 16; k++) fq.push_back(k);
    run_fetches("rnd_sweep");
  endtask

  initial begin
    test_reset();
    test_load();
    test_err_boundary();
    test_priority();
    test_hold();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
